// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller and the datapath.
//   - opcode values (IR[31:26])
//   - controller state enum
//   - ALUOp / PCSrc / ALUSrcB / regdst / memtoreg select encodings
//   - ctrl_t: the packed control vector produced per state
package mc_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [SEL_W-1:0] ALUOP_SLT   = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALURES = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

    localparam logic [SEL_W-1:0] REGDST_RT  = 2'b00;
    localparam logic [SEL_W-1:0] REGDST_RD  = 2'b01;
    localparam logic [SEL_W-1:0] REGDST_R31 = 2'b10;

    localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

    // Encoding 4'hF is left unused; it decodes to all-zero and returns to FETCH.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTEXE   = 4'd6,
        S_RTWB    = 4'd7,
        S_ADDIEXE = 4'd8,
        S_SLTIEXE = 4'd9,
        S_IWB     = 4'd10,
        S_BEQ     = 4'd11,
        S_BNE     = 4'd12,
        S_JUMP    = 4'd13,
        S_JAL     = 4'd14
    } state_e;

    typedef struct packed {
        logic             ALUSrcA;
        logic             memread;
        logic             memwrite;
        logic             regwrite;
        logic             IorD;
        logic             IRWrite;
        logic             PCWrite;
        logic             PCWriteCondbeq;
        logic             PCWriteCondbne;
        logic [SEL_W-1:0] PCSrc;
        logic [SEL_W-1:0] ALUSrcB;
        logic [SEL_W-1:0] ALUOp;
        logic [SEL_W-1:0] regdst;
        logic [SEL_W-1:0] memtoreg;
        logic             instr_done;
    } ctrl_t;

    // True for every opcode the controller has an execution path for.
    function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_J, OP_JAL, OP_ADDI, OP_SLTI: is_legal = 1'b1;
            default:                        is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bundle.
//   opcode : IR[31:26] from datapath
//   all remaining signals : datapath control inputs driven by the controller
//   master modport = controller, slave modport = datapath
interface mc_controller_if;
    import mc_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                ALUSrcA;
    logic                memread;
    logic                memwrite;
    logic                regwrite;
    logic                IorD;
    logic                IRWrite;
    logic                PCWrite;
    logic                PCWriteCondbeq;
    logic                PCWriteCondbne;
    logic [SEL_W-1:0]    PCSrc;
    logic [SEL_W-1:0]    ALUSrcB;
    logic [SEL_W-1:0]    ALUOp;
    logic [SEL_W-1:0]    regdst;
    logic [SEL_W-1:0]    memtoreg;
    logic                instr_done;
    logic                illegal;

    modport master (
        input  opcode,
        output ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite, PCWrite,
               PCWriteCondbeq, PCWriteCondbne, PCSrc, ALUSrcB, ALUOp,
               regdst, memtoreg, instr_done, illegal
    );

    modport slave (
        output opcode,
        input  ALUSrcA, memread, memwrite, regwrite, IorD, IRWrite, PCWrite,
               PCWriteCondbeq, PCWriteCondbne, PCSrc, ALUSrcB, ALUOp,
               regdst, memtoreg, instr_done, illegal
    );

endinterface

// File: rtl/mc_outdecode.sv
// Combinational state -> control-vector decode (Moore outputs).
//   state_i : current controller state
//   ctrl_o  : datapath control vector for that state
module mc_outdecode
    import mc_pkg::*;
(
    input  state_e state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.IRWrite = 1'b1;
                ctrl_o.PCWrite = 1'b1;
                ctrl_o.ALUSrcB = SRCB_FOUR;
            end
            // Branch target precomputed into ALUOut while the opcode decodes.
            S_DECODE: ctrl_o.ALUSrcB = SRCB_IMMSH;
            S_MEMADR, S_ADDIEXE: begin
                ctrl_o.ALUSrcA = 1'b1;
                ctrl_o.ALUSrcB = SRCB_IMM;
                ctrl_o.ALUOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_o.memread = 1'b1;
                ctrl_o.IorD    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.memtoreg   = M2R_MDR;
                ctrl_o.regdst     = REGDST_RT;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.memwrite   = 1'b1;
                ctrl_o.IorD       = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_RTEXE: begin
                ctrl_o.ALUSrcA = 1'b1;
                ctrl_o.ALUSrcB = SRCB_B;
                ctrl_o.ALUOp   = ALUOP_FUNCT;
            end
            S_RTWB: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.regdst     = REGDST_RD;
                ctrl_o.memtoreg   = M2R_ALUOUT;
                ctrl_o.instr_done = 1'b1;
            end
            S_SLTIEXE: begin
                ctrl_o.ALUSrcA = 1'b1;
                ctrl_o.ALUSrcB = SRCB_IMM;
                ctrl_o.ALUOp   = ALUOP_SLT;
            end
            S_IWB: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.regdst     = REGDST_RT;
                ctrl_o.memtoreg   = M2R_ALUOUT;
                ctrl_o.instr_done = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.ALUSrcA        = 1'b1;
                ctrl_o.ALUSrcB        = SRCB_B;
                ctrl_o.ALUOp          = ALUOP_SUB;
                ctrl_o.PCWriteCondbeq = 1'b1;
                ctrl_o.PCSrc          = PCSRC_ALUOUT;
                ctrl_o.instr_done     = 1'b1;
            end
            S_BNE: begin
                ctrl_o.ALUSrcA        = 1'b1;
                ctrl_o.ALUSrcB        = SRCB_B;
                ctrl_o.ALUOp          = ALUOP_SUB;
                ctrl_o.PCWriteCondbne = 1'b1;
                ctrl_o.PCSrc          = PCSRC_ALUOUT;
                ctrl_o.instr_done     = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.PCWrite    = 1'b1;
                ctrl_o.PCSrc      = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            // r31 gets the already-incremented PC, sampled before this edge.
            S_JAL: begin
                ctrl_o.PCWrite    = 1'b1;
                ctrl_o.PCSrc      = PCSRC_JUMP;
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.regdst     = REGDST_R31;
                ctrl_o.memtoreg   = M2R_PC;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS-subset control unit.
//   clk : rising-edge clock
//   rst : synchronous active-high reset; forces all controls to 0 while high
//   bus : master side of mc_controller_if (opcode in, datapath controls out)
module mc_controller
    import mc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    mc_controller_if.master  bus
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl_c;
    logic   illegal_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; opcode only matters in DECODE and MEMADR.
    always_comb begin
        state_d   = S_FETCH;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEXE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_BNE:       state_d = S_BNE;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    OP_ADDI:      state_d = S_ADDIEXE;
                    OP_SLTI:      state_d = S_SLTIEXE;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_RTEXE:   state_d = S_RTWB;
            S_ADDIEXE: state_d = S_IWB;
            S_SLTIEXE: state_d = S_IWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_outdecode u_outdecode (
        .state_i (state_q),
        .ctrl_o  (ctrl_c)
    );

    // Output gating: reset blanks every enable so nothing is written.
    always_comb begin
        bus.ALUSrcA        = 1'b0;
        bus.memread        = 1'b0;
        bus.memwrite       = 1'b0;
        bus.regwrite       = 1'b0;
        bus.IorD           = 1'b0;
        bus.IRWrite        = 1'b0;
        bus.PCWrite        = 1'b0;
        bus.PCWriteCondbeq = 1'b0;
        bus.PCWriteCondbne = 1'b0;
        bus.PCSrc          = '0;
        bus.ALUSrcB        = '0;
        bus.ALUOp          = '0;
        bus.regdst         = '0;
        bus.memtoreg       = '0;
        bus.instr_done     = 1'b0;
        bus.illegal        = 1'b0;
        if (!rst) begin
            bus.ALUSrcA        = ctrl_c.ALUSrcA;
            bus.memread        = ctrl_c.memread;
            bus.memwrite       = ctrl_c.memwrite;
            bus.regwrite       = ctrl_c.regwrite;
            bus.IorD           = ctrl_c.IorD;
            bus.IRWrite        = ctrl_c.IRWrite;
            bus.PCWrite        = ctrl_c.PCWrite;
            bus.PCWriteCondbeq = ctrl_c.PCWriteCondbeq;
            bus.PCWriteCondbne = ctrl_c.PCWriteCondbne;
            bus.PCSrc          = ctrl_c.PCSrc;
            bus.ALUSrcB        = ctrl_c.ALUSrcB;
            bus.ALUOp          = ctrl_c.ALUOp;
            bus.regdst         = ctrl_c.regdst;
            bus.memtoreg       = ctrl_c.memtoreg;
            bus.instr_done     = ctrl_c.instr_done | illegal_c;
            bus.illegal        = illegal_c;
        end
    end

endmodule
